// File: rtl/cla_seq_ctrl.sv
// Sequential wide adder: one 8-bit carry-lookahead slice is reused LSB-first over NBYTES cycles.
// Optional subtract mode is compiled in with `define CLA_SUB_EN (adds the sub input port).
module cla_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [8*NBYTES-1:0]   op_a,
  input  logic [8*NBYTES-1:0]   op_b,
  input  logic                  cin,
`ifdef CLA_SUB_EN
  input  logic                  sub,
`endif
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*NBYTES-1:0]   result,
  output logic                  cout,
  output logic                  busy
);

  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST = IW'(NBYTES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nx;
  logic [IW-1:0] idx;
  logic          carry;
  logic [W-1:0]  a_reg, b_reg;
  logic [7:0]    s_sum;
  logic          s_cout;
  logic          sub_i;

`ifdef CLA_SUB_EN
  assign sub_i = sub;
`else
  assign sub_i = 1'b0;
`endif

  // Each carry is the full lookahead expansion of generate/propagate terms.
  function automatic logic [8:0] cla8(input logic [7:0] a, input logic [7:0] b, input logic c0);
    logic [7:0] g, p;
    logic [8:0] c;
    logic       t, pp;
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = c0;
    for (int unsigned i = 0; i < 8; i++) begin
      t  = g[i];
      pp = p[i];
      for (int unsigned k = 1; k <= i; k++) begin
        t  = t | (pp & g[i-k]);
        pp = pp & p[i-k];
      end
      c[i+1] = t | (pp & c0);
    end
    return {c[8], p ^ c[7:0]};
  endfunction

  always_comb begin
    {s_cout, s_sum} = cla8(a_reg[8*idx +: 8], b_reg[8*idx +: 8], carry);
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) state_nx = RUN;
      end
      RUN:  if (idx == LAST) state_nx = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      cout   <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: if (in_valid) begin
          // Inverting B once at capture is equivalent to inverting each byte at the slice.
          a_reg <= op_a;
          b_reg <= sub_i ? ~op_b : op_b;
          carry <= sub_i | cin;
          idx   <= '0;
        end
        RUN: begin
          result[8*idx +: 8] <= s_sum;
          carry              <= s_cout;
          if (idx == LAST) cout <= s_cout;
          else             idx  <= idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
